reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 alloc_req  in  1  issue stage requests one entry.
REQ-004 alloc_rd  in  5  architectural destination register of the allocating instruction.
REQ-005 alloc_tag  out  5  tag granted to an alloc_req this cycle; combinational; equals tail index + 1.
REQ-006 full  out  1  all 8 entries busy; combinational from registered count.
REQ-007 cmp_valid / cmp_valid2  in  1  completion ports 1 and 2 from the execution units.
REQ-008 cmp_tag / cmp_tag2  in  5  tag of the completing instruction.
REQ-009 cmp_value / cmp_value2  in  32  result value.
REQ-010 bc_tag / bc_tag2  out  5  result broadcast to the reservation stations; 0 = no broadcast.
REQ-011 bc_value / bc_value2  out  32  broadcast value.
REQ-012 lk_tag_a / lk_tag_b  in  5  operand tag lookups for issue.
REQ-013 lk_ready_a / lk_ready_b  out  1  looked-up entry is busy and done.
REQ-014 lk_value_a / lk_value_b  out  32  value of the looked-up entry; 0 when not ready.
REQ-015 commit_we / commit_we2  out  1  register file write strobes, slot 1 is older.
REQ-016 commit_rd / commit_rd2  out  5  register file write address.
REQ-017 commit_value / commit_value2  out  32  register file write data.
REQ-018 flush  in  1  synchronous discard of all entries.

Function
REQ-019 Circular buffer: 8 entries; each holds busy, done, rd[4:0], value[31:0]; head, tail 3-bit, count 4-bit (0..8).
REQ-020 Tag encoding: entry i uses tag i+1 (1..8); tag 0 is reserved for "none" and is never allocated.
REQ-021 Allocation: alloc_req && !full sets busy=1, done=0, rd=alloc_rd at tail; tail increments mod 8. alloc_req while full is ignored, even if a commit frees an entry that cycle.
REQ-022 Completion: a cmp port with valid, tag in 1..8, and the target entry busy sets done=1 and stores the value. Tag 0, tag >8, or a non-busy target is ignored.
REQ-023 Completion conflict: if both ports carry the same valid tag, port 1 wins.
REQ-024 Broadcast: registered, one cycle after completion. bc_tag/bc_value mirror cmp_tag/cmp_value of each accepted completion; bc_tag=0 and bc_value=0 otherwise.
REQ-025 Lookup: combinational. Tag 0, or an entry that is not both busy and done, gives ready=0 and value=0. A lookup in the broadcast cycle sees done=1, so no same-cycle bypass exists.
REQ-026 Commit: registered outputs. If the head entry is busy and done, slot 1 commits it. If head+1 is also busy and done, slot 2 commits it in the same cycle.
REQ-027 A committed entry clears busy and done; head advances by the number of commits, mod 8.
REQ-028 A completion is not committable in the cycle it is written; done is first visible to commit logic on the next cycle.
REQ-029 Count update: next count = count + alloc − commits, covering simultaneous alloc and 2 commits. Wrap of head and tail past entry 7 is seamless.
REQ-030 Flush: clears all busy/done, head, tail and count. Next-cycle commit_we/2 and bc_tag/2 are 0. Flush has priority over alloc, completion and commit in that cycle.

Reset
REQ-031 rst low: all entries cleared; head=tail=count=0; full=0, alloc_tag=1. bc_*, commit_* and lk_* outputs are 0.
REQ-032 Reset asserted mid-operation discards all in-flight entries without committing them.

Structure
REQ-033 Package rob_pkg: ROB_DEPTH=8, TAG_W=5, DATA_W=32, REG_W=5, TAG_NONE=0, and the entry struct type.
REQ-034 Sub-module rob_commit_sel: combinational selection of 0/1/2 committable entries from head; all other logic stays in reorder_buffer.

Verification
REQ-035 Reset, then 3 allocs (rd 1,2,3) -> alloc_tag 1,2,3; count=3; full=0; no commits.
REQ-036 Complete tag 2 (0xAA) -> next cycle bc_tag=2, bc_value=0xAA; lookup tag 2 ready=1; commit_we stays 0 because head tag 1 is not done.
REQ-037 Complete tags 1 (0x11) and 3 (0x33) on both ports in one cycle -> broadcast of both next cycle. The following cycle, tags 1 and 2 commit (rd 1 then 2, 0x11 then 0xAA); tag 3 commits the cycle after.
REQ-038 Fill 8 entries -> full=1; a 9th alloc_req is ignored; after 2 commits, allocation resumes with tags 1 and 2 (wrap-around).
REQ-039 Both ports complete tag 4 with 0x4 and 0x5 -> stored and broadcast value is 0x4; a completion to a non-busy tag produces bc_tag=0.
REQ-040 Flush with 5 busy entries plus a same-cycle alloc and completion -> count=0, no broadcast or commit next cycle, next alloc_tag=1.

Source files
------------

// File: rtl/rob_pkg.sv
// Reorder buffer shared definitions.
// Sizes, the "no tag" encoding, the per-entry state record, the broadcast and
// commit records, and helpers that map tags (1..ROB_DEPTH) onto entry
// indices (0..ROB_DEPTH-1).
package rob_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = 5;
  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int IDX_W     = 3;
  localparam int CNT_W     = 4;
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } rob_bc_t;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
  } rob_commit_t;

  // Tag 0 means "none"; tags above ROB_DEPTH name no entry.
  function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
    return (t != TAG_NONE) && (t <= TAG_W'(ROB_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] tag2idx(input logic [TAG_W-1:0] t);
    logic [TAG_W-1:0] i;
    i = t - TAG_W'(1);
    return i[IDX_W-1:0];
  endfunction
endpackage

// File: rtl/rob_commit_sel.sv
// Commit selection: picks up to two in-order committable entries starting at
// head. Slot 0 is the head entry; slot 1 (head+1) only commits when slot 0 does.
//   head     : current head index
//   ready    : per-entry busy & done
//   sel      : per-slot commit enable
//   idx      : per-slot entry index
//   n_commit : number of commits this cycle (0..2)
module rob_commit_sel
  import rob_pkg::*;
(
  input  logic [IDX_W-1:0]            head,
  input  logic [ROB_DEPTH-1:0]        ready,
  output logic [1:0]                  sel,
  output logic [1:0][IDX_W-1:0]       idx,
  output logic [1:0]                  n_commit
);
  // Index arithmetic wraps naturally at IDX_W bits.
  assign idx[0]   = head;
  assign idx[1]   = head + IDX_W'(1);
  assign sel[0]   = ready[idx[0]];
  assign sel[1]   = sel[0] && ready[idx[1]];
  assign n_commit = {1'b0, sel[0]} + {1'b0, sel[1]};
endmodule

// File: rtl/reorder_buffer.sv
// 8-entry reorder buffer with one allocation port, two completion ports,
// two registered result broadcasts, two combinational operand lookups and
// up to two in-order commits per cycle.
//   clk, rst (async, active low), flush (sync discard of all entries)
//   alloc_req/alloc_rd -> alloc_tag (tail+1), full
//   cmp_valid[2]/cmp_tag[2]/cmp_value[2] -> bc_tag[2]/bc_value[2] (next cycle)
//   lk_tag_a/b -> lk_ready_a/b, lk_value_a/b
//   commit_we[2]/commit_rd[2]/commit_value[2] (registered, slot 1 older)
module reorder_buffer
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              full,
  input  logic              cmp_valid,
  input  logic [TAG_W-1:0]  cmp_tag,
  input  logic [DATA_W-1:0] cmp_value,
  input  logic              cmp_valid2,
  input  logic [TAG_W-1:0]  cmp_tag2,
  input  logic [DATA_W-1:0] cmp_value2,
  output logic [TAG_W-1:0]  bc_tag,
  output logic [DATA_W-1:0] bc_value,
  output logic [TAG_W-1:0]  bc_tag2,
  output logic [DATA_W-1:0] bc_value2,
  input  logic [TAG_W-1:0]  lk_tag_a,
  input  logic [TAG_W-1:0]  lk_tag_b,
  output logic              lk_ready_a,
  output logic              lk_ready_b,
  output logic [DATA_W-1:0] lk_value_a,
  output logic [DATA_W-1:0] lk_value_b,
  output logic              commit_we,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_value,
  output logic              commit_we2,
  output logic [REG_W-1:0]  commit_rd2,
  output logic [DATA_W-1:0] commit_value2,
  input  logic              flush
);
  rob_entry_t [ROB_DEPTH-1:0] rob_q, rob_d;
  logic [IDX_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;
  rob_bc_t [1:0]              bc_q, bc_d;
  rob_commit_t [1:0]          cm_q, cm_d;

  logic [ROB_DEPTH-1:0]       ready;
  logic [1:0]                 cm_sel;
  logic [1:0][IDX_W-1:0]      cm_idx;
  logic [1:0]                 n_commit;
  logic [1:0]                 cv, acc;
  logic [1:0][TAG_W-1:0]      ct;
  logic [1:0][DATA_W-1:0]     cd;
  logic                       do_alloc;

  assign full      = (count_q == CNT_W'(ROB_DEPTH));
  assign alloc_tag = TAG_W'(tail_q) + TAG_W'(1);
  // A full buffer refuses allocation even if a commit frees a slot this cycle.
  assign do_alloc  = alloc_req && !full;

  always_comb begin
    ready = '0;
    for (int i = 0; i < ROB_DEPTH; i++) ready[i] = rob_q[i].busy && rob_q[i].done;
  end

  // Works from registered done bits, so a result written this cycle is not
  // committable until the next one.
  rob_commit_sel u_commit_sel (
    .head     (head_q),
    .ready    (ready),
    .sel      (cm_sel),
    .idx      (cm_idx),
    .n_commit (n_commit)
  );

  // Completion acceptance; on a same-tag collision port 1 wins and port 2 is
  // dropped entirely (no store, no broadcast).
  always_comb begin
    cv  = {cmp_valid2, cmp_valid};
    ct  = {cmp_tag2, cmp_tag};
    cd  = {cmp_value2, cmp_value};
    acc = '0;
    for (int p = 0; p < 2; p++)
      acc[p] = cv[p] && tag_in_range(ct[p]) && rob_q[tag2idx(ct[p])].busy;
    if (cv[0] && (ct[1] == ct[0])) acc[1] = 1'b0;
  end

  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    bc_d    = '0;
    cm_d    = '0;
    if (flush) begin
      rob_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          rob_d[tag2idx(ct[p])].done  = 1'b1;
          rob_d[tag2idx(ct[p])].value = cd[p];
          bc_d[p].tag   = ct[p];
          bc_d[p].value = cd[p];
        end
      end
      // Commit after completion so a retiring entry always ends up cleared;
      // commit data comes from the registered entry.
      for (int s = 0; s < 2; s++) begin
        if (cm_sel[s]) begin
          rob_d[cm_idx[s]] = '0;
          cm_d[s].we    = 1'b1;
          cm_d[s].rd    = rob_q[cm_idx[s]].rd;
          cm_d[s].value = rob_q[cm_idx[s]].value;
        end
      end
      // The tail entry is never busy when allocation is allowed, so it
      // cannot collide with a commit or an accepted completion.
      if (do_alloc) begin
        rob_d[tail_q].busy  = 1'b1;
        rob_d[tail_q].done  = 1'b0;
        rob_d[tail_q].rd    = alloc_rd;
        rob_d[tail_q].value = '0;
      end
      head_d  = head_q + IDX_W'(n_commit);
      tail_d  = tail_q + IDX_W'(do_alloc);
      count_d = count_q + CNT_W'(do_alloc) - CNT_W'(n_commit);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      bc_q    <= '0;
      cm_q    <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      bc_q    <= bc_d;
      cm_q    <= cm_d;
    end
  end

  assign bc_tag        = bc_q[0].tag;
  assign bc_value      = bc_q[0].value;
  assign bc_tag2       = bc_q[1].tag;
  assign bc_value2     = bc_q[1].value;
  assign commit_we     = cm_q[0].we;
  assign commit_rd     = cm_q[0].rd;
  assign commit_value  = cm_q[0].value;
  assign commit_we2    = cm_q[1].we;
  assign commit_rd2    = cm_q[1].rd;
  assign commit_value2 = cm_q[1].value;

  // Lookup sees only registered state: no bypass from this cycle's completion.
  always_comb begin
    lk_ready_a = tag_in_range(lk_tag_a) && ready[tag2idx(lk_tag_a)];
    lk_ready_b = tag_in_range(lk_tag_b) && ready[tag2idx(lk_tag_b)];
    lk_value_a = lk_ready_a ? rob_q[tag2idx(lk_tag_a)].value : '0;
    lk_value_b = lk_ready_b ? rob_q[tag2idx(lk_tag_b)].value : '0;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer. The reference model is an in-order
// queue of in-flight instructions; per-cycle expected broadcasts and commits
// are queued with the cycle in which they must appear, and a negedge monitor
// pops and compares them against the DUT outputs.
module tb_reorder_buffer;
  logic        clk = 1'b0, rst = 1'b0;
  logic        alloc_req = 1'b0, full;
  logic [4:0]  alloc_rd = '0, alloc_tag;
  logic        cmp_valid = 1'b0, cmp_valid2 = 1'b0;
  logic [4:0]  cmp_tag = '0, cmp_tag2 = '0;
  logic [31:0] cmp_value = '0, cmp_value2 = '0;
  logic [4:0]  bc_tag, bc_tag2;
  logic [31:0] bc_value, bc_value2;
  logic [4:0]  lk_tag_a = '0, lk_tag_b = '0;
  logic        lk_ready_a, lk_ready_b;
  logic [31:0] lk_value_a, lk_value_b;
  logic        commit_we, commit_we2;
  logic [4:0]  commit_rd, commit_rd2;
  logic [31:0] commit_value, commit_value2;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag), .full(full),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_value(cmp_value),
    .cmp_valid2(cmp_valid2), .cmp_tag2(cmp_tag2), .cmp_value2(cmp_value2),
    .bc_tag(bc_tag), .bc_value(bc_value), .bc_tag2(bc_tag2), .bc_value2(bc_value2),
    .lk_tag_a(lk_tag_a), .lk_tag_b(lk_tag_b), .lk_ready_a(lk_ready_a), .lk_ready_b(lk_ready_b),
    .lk_value_a(lk_value_a), .lk_value_b(lk_value_b),
    .commit_we(commit_we), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_we2(commit_we2), .commit_rd2(commit_rd2), .commit_value2(commit_value2),
    .flush(flush)
  );

  typedef struct { int tag; int rd; bit done; int unsigned value; } ment_t;
  typedef struct { int cyc; int slot; int key; int unsigned value; } exp_t;

  ment_t rob[$];
  exp_t  bc_q[$], cm_q[$];
  int    next_tag = 1;
  int    cyc = 0;
  int    vectors = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int find(input int t);
    for (int i = 0; i < rob.size(); i++) if (rob[i].tag == t) return i;
    return -1;
  endfunction

  // Monitor: every negedge, collect what is due this cycle and compare.
  initial begin
    exp_t e;
    logic [31:0] bt[2], bv[2], cw[2], cr[2], cvv[2];
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin bt[s] = 0; bv[s] = 0; cw[s] = 0; cr[s] = 0; cvv[s] = 0; end
      while (bc_q.size() > 0 && bc_q[0].cyc <= cyc) begin
        e = bc_q.pop_front(); bt[e.slot] = e.key; bv[e.slot] = e.value;
      end
      while (cm_q.size() > 0 && cm_q[0].cyc <= cyc) begin
        e = cm_q.pop_front(); cw[e.slot] = 1; cr[e.slot] = e.key; cvv[e.slot] = e.value;
      end
      chk("bc_tag", bc_tag, bt[0]);          chk("bc_value", bc_value, bv[0]);
      chk("bc_tag2", bc_tag2, bt[1]);        chk("bc_value2", bc_value2, bv[1]);
      chk("commit_we", commit_we, cw[0]);    chk("commit_rd", commit_rd, cr[0]);
      chk("commit_value", commit_value, cvv[0]);
      chk("commit_we2", commit_we2, cw[1]);  chk("commit_rd2", commit_rd2, cr[1]);
      chk("commit_value2", commit_value2, cvv[1]);
    end
  end

  // One cycle of stimulus; called just after a rising edge.
  task automatic step(input bit a, input int rd,
                      input bit v1, input int t1, input int unsigned d1,
                      input bit v2, input int t2, input int unsigned d2,
                      input bit fl, input int la, input int lb);
    int n, i1, i2, ia, ib, sz0;
    alloc_req = a; alloc_rd = 5'(rd);
    cmp_valid = v1; cmp_tag = 5'(t1); cmp_value = d1;
    cmp_valid2 = v2; cmp_tag2 = 5'(t2); cmp_value2 = d2;
    flush = fl; lk_tag_a = 5'(la); lk_tag_b = 5'(lb);
    #1;
    chk("alloc_tag", alloc_tag, next_tag);
    chk("full", full, rob.size() == 8);
    ia = find(la); ib = find(lb);
    chk("lk_ready_a", lk_ready_a, ia >= 0 && rob[ia].done);
    chk("lk_value_a", lk_value_a, (ia >= 0 && rob[ia].done) ? rob[ia].value : 0);
    chk("lk_ready_b", lk_ready_b, ib >= 0 && rob[ib].done);
    chk("lk_value_b", lk_value_b, (ib >= 0 && rob[ib].done) ? rob[ib].value : 0);
    if (fl) begin
      rob.delete(); next_tag = 1;
    end else begin
      sz0 = rob.size();
      n = 0;
      if (sz0 > 0 && rob[0].done) n = 1;
      if (n == 1 && sz0 > 1 && rob[1].done) n = 2;
      for (int k = 0; k < n; k++) cm_q.push_back('{cyc + 1, k, rob[k].rd, rob[k].value});
      i1 = v1 ? find(t1) : -1;
      i2 = (v2 && !(v1 && t1 == t2)) ? find(t2) : -1;
      if (i1 >= 0) bc_q.push_back('{cyc + 1, 0, t1, d1});
      if (i2 >= 0) bc_q.push_back('{cyc + 1, 1, t2, d2});
      if (i1 >= 0) begin rob[i1].done = 1; rob[i1].value = d1; end
      if (i2 >= 0) begin rob[i2].done = 1; rob[i2].value = d2; end
      for (int k = 0; k < n; k++) void'(rob.pop_front());
      if (a && sz0 < 8) begin
        rob.push_back('{next_tag, rd, 1'b0, 0});
        next_tag = next_tag % 8 + 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int la = 0, input int lb = 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, la, lb);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    alloc_req = 0; cmp_valid = 0; cmp_valid2 = 0; flush = 0; lk_tag_a = 1; lk_tag_b = 0;
    rob.delete(); next_tag = 1; bc_q.delete(); cm_q.delete();
    #1;
    chk("rst_alloc_tag", alloc_tag, 1);
    chk("rst_full", full, 0);
    chk("rst_lk_ready", lk_ready_a, 0);
    chk("rst_lk_value", lk_value_a, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int t1, t2, nd;
    bit v1, v2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc_tag", alloc_tag, 1);
    chk("rst_full", full, 0);
    chk("rst_commit_we", commit_we, 0);
    chk("rst_bc_tag", bc_tag, 0);
    rst = 1'b1;

    // Three allocations, then an out-of-order completion.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 32'hAA, 0, 0, 0, 0, 2, 1);
    idle(2, 1);
    // Tags 1 and 3 together; 1 and 2 retire together, 3 the cycle after.
    step(0, 0, 1, 1, 32'h11, 1, 3, 32'h33, 0, 1, 3);
    repeat (4) idle(3, 2);

    // In-flight work discarded by reset, then fill to full.
    step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 8, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 10 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h101, 1, 2, 32'h202, 0, 0, 0);
    step(1, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Same-tag collision on both ports, plus out-of-range tags.
    step(0, 0, 1, 4, 32'h4, 1, 4, 32'h5, 0, 0, 0);
    step(0, 0, 1, 0, 32'h77, 1, 12, 32'h88, 0, 4, 12);
    idle(4, 0);

    // Flush with busy entries plus same-cycle alloc and completion.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 9, 1, 1, 32'h55, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 3, 32'h66, 0, 0, 0, 0, 1, 3);
    step(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int it = 0; it < 600; it++) begin
      if (it == 300) do_reset();
      nd = 0;
      for (int i = 0; i < rob.size(); i++) if (!rob[i].done) nd++;
      v1 = $urandom_range(0, 1); v2 = $urandom_range(0, 1);
      t1 = (nd > 0 && $urandom_range(0, 3) != 0) ? rob[$urandom_range(0, rob.size() - 1)].tag
                                                 : int'($urandom_range(0, 15));
      t2 = ($urandom_range(0, 5) == 0) ? t1
           : (rob.size() > 0 && $urandom_range(0, 3) != 0) ? rob[$urandom_range(0, rob.size() - 1)].tag
           : int'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 6, int'($urandom_range(0, 31)),
           v1, t1, $urandom, v2, t2, $urandom,
           $urandom_range(0, 59) == 0,
           int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
    end

    repeat (3) idle();
    chk("bc_drain", bc_q.size(), 0);
    chk("commit_drain", cm_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
